// File: rtl/board_pkg.sv
// Shared board-level definitions used by the button debouncer.
// - CNT_W(n): width of an unsigned counter that can hold 0..n.
// - DEFAULT_N_BUTTONS / DEFAULT_STABLE_TICKS: default parameter values.
package board_pkg;

  localparam int DEFAULT_N_BUTTONS    = 4;
  localparam int DEFAULT_STABLE_TICKS = 4;

  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, qualification counter,
// debounced state bit and registered press/release event pulses.
// Ports:
//   clk         system clock (rising edge)
//   rst         synchronous active-high reset
//   tick        sample strobe (single-cycle pulse or held high)
//   btn_raw     asynchronous raw level, 1 = pressed
//   btn_state   debounced level
//   btn_press   one-cycle pulse coincident with a 0->1 state change
//   btn_release one-cycle pulse coincident with a 1->0 state change
module debounce_channel
  import board_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_state,
  output logic btn_press,
  output logic btn_release
);

  if (STABLE_TICKS < 1) begin : g_bad_ticks
    $error("debounce_channel: STABLE_TICKS must be >= 1");
  end

  localparam int             W       = CNT_W(STABLE_TICKS);
  localparam logic [W-1:0]   CNT_MAX = W'(STABLE_TICKS - 1);
  localparam logic [W-1:0]   CNT_ONE = W'(1);

  logic         meta_q, meta_d;
  logic         sync_q, sync_d;
  logic         state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         press_q, press_d;
  logic         release_q, release_d;

  always_comb begin
    meta_d    = btn_raw;
    sync_d    = meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync_q == state_q) begin
      // Any return to the accepted level restarts qualification, and
      // beats a tick arriving in the same cycle.
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_MAX) begin
        state_d   = sync_q;
        cnt_d     = '0;
        press_d   = sync_q;
        release_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BUTTONS raw push-button inputs using the divider's
// single-cycle output_pulse as the shared sample tick.
// Ports:
//   clk          system clock (rising edge)
//   rst          synchronous active-high reset
//   tick         sample strobe shared by all channels
//   btn_raw      asynchronous raw levels, 1 = pressed
//   btn_state    debounced levels
//   btn_press    one-cycle pulse per bit on a 0->1 state change
//   btn_release  one-cycle pulse per bit on a 1->0 state change
module button_debouncer
  import board_pkg::*;
#(
  parameter int N_BUTTONS    = DEFAULT_N_BUTTONS,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_state,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);

  if (STABLE_TICKS < 1) begin : g_bad_ticks
    $error("button_debouncer: STABLE_TICKS must be >= 1");
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .btn_raw     (btn_raw[i]),
      .btn_state   (btn_state[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule
